// File: rtl/det_arbiter.sv
// Purpose: round-robin arbiter for two serial sources, plus a 000/111 detector over overlapping 3-bit windows.
// Latency: gnt rises 1 cycle after req; done pulses FRAME cycles after gnt rises; match trails its third bit by 1 cycle.
// Backpressure: none; withdrawing the granted req aborts the frame, and the non-granted source waits in req.
module det_arbiter #(
  parameter int FRAME = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       x0,
  input  logic       x1,
  output logic [1:0] gnt,
  output logic       match,
  output logic       done,
  output logic       abort,
  output logic [3:0] hit_cnt,
  output logic       done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(FRAME - 1);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       match_q, match_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic       done_id_q, done_id_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  // Only the two previous samples need storing; the third window bit is the live input.
  logic [1:0] hist_q, hist_d;
  logic       last_q, last_d;
  logic       src_q, src_d;

  logic       x_sel;
  logic       req_sel;

  assign x_sel   = src_q ? x1 : x0;
  assign req_sel = req[src_q];

  // Next-state, grant, window detection and completion/abort decisions.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    match_d   = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    hit_cnt_d = hit_cnt_q;
    done_id_d = done_id_q;
    bit_cnt_d = bit_cnt_q;
    hist_d    = hist_q;
    last_d    = last_q;
    src_d     = src_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the source not served last wins; otherwise the sole requester.
          src_d     = (req == 2'b11) ? ~last_q : req[1];
          gnt_d     = (src_d) ? 2'b10 : 2'b01;
          bit_cnt_d = 4'd0;
          hist_d    = 2'b00;
          hit_cnt_d = 4'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!req_sel) begin
          // Withdrawal: drop the frame without sampling, keep the partial hit count.
          gnt_d     = 2'b00;
          abort_d   = 1'b1;
          done_id_d = src_q;
          last_d    = src_q;
          state_d   = IDLE;
        end else begin
          hist_d    = {hist_q[0], x_sel};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if ((bit_cnt_q >= 4'd2) && (hist_q == {2{x_sel}})) begin
            match_d   = 1'b1;
            hit_cnt_d = hit_cnt_q + 4'd1;
          end
          if (bit_cnt_q == LAST_BIT) begin
            gnt_d     = 2'b00;
            done_d    = 1'b1;
            done_id_d = src_q;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        // No grant here, which forces one idle cycle between frames.
        last_d  = src_q;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      hit_cnt_q <= 4'd0;
      done_id_q <= 1'b0;
      bit_cnt_q <= 4'd0;
      hist_q    <= 2'b00;
      last_q    <= 1'b1;
      src_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      match_q   <= match_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      hit_cnt_q <= hit_cnt_d;
      done_id_q <= done_id_d;
      bit_cnt_q <= bit_cnt_d;
      hist_q    <= hist_d;
      last_q    <= last_d;
      src_q     <= src_d;
    end
  end

  assign gnt     = gnt_q;
  assign match   = match_q;
  assign done    = done_q;
  assign abort   = abort_q;
  assign hit_cnt = hit_cnt_q;
  assign done_id = done_id_q;

endmodule
